// File: rtl/dart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dart_pkg : shared types and constants for the dart scorer          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package dart_pkg;

    typedef enum logic [1:0] {
        PLAY   = 2'd0,
        FINISH = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [4:0] MAX_SCORE = 5'd31;
    localparam logic [3:0] MAX_PTS   = 4'd10;
    // Feedback taps for x^8+x^6+x^5+x^4+1 (register bits 7,5,4,3)
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [4:0] sat_add(input logic [4:0] a, input logic [3:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {2'b00, b};
        return (s > {1'b0, MAX_SCORE}) ? MAX_SCORE : s[4:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/dart_lfsr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dart_lfsr : free-running 8-bit LFSR mapped to 0..10 dart points    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module dart_lfsr
    import dart_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] pts
);

    logic [7:0] r_lfsr;
    logic [3:0] w_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], ^(r_lfsr & LFSR_TAPS)};
        end
    end

    // Fold nibble values 11..15 back into 6..10
    assign w_n = r_lfsr[3:0];
    assign pts = (w_n > MAX_PTS) ? (w_n - 4'd5) : w_n;

endmodule
`default_nettype wire

// File: rtl/digital_dart_game.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | digital_dart_game : turn-based dart scorer with winner detection   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module digital_dart_game
    import dart_pkg::*;
#(
    parameter int         NUM_PLAYERS = 5,
    parameter int         NUM_ROUNDS  = 3,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       throw_button,
    output logic [2:0] player_id,
    output logic [4:0] score_display,
    output logic [4:0] final_score,
    output logic [4:0] winner
);

    localparam int ROUND_W = $clog2(NUM_ROUNDS + 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [4:0]           r_tot [NUM_PLAYERS];
    logic [2:0]           r_pid;
    logic [ROUND_W-1:0]   r_round;
    logic                 r_btn_q;
    logic [4:0]           r_disp;
    logic [4:0]           r_final;
    logic [4:0]           r_winner;

    logic [3:0]           w_pts;
    logic                 w_throw;
    logic                 w_last_player;
    logic                 w_last_round;
    logic [4:0]           w_new_tot;
    logic [2:0]           w_best_idx;
    logic [4:0]           w_best_val;

    dart_lfsr #(
        .LFSR_SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .pts   (w_pts)
    );

    assign w_throw       = throw_button & ~r_btn_q;
    assign w_last_player = (r_pid == 3'(NUM_PLAYERS - 1));
    assign w_last_round  = (r_round == ROUND_W'(NUM_ROUNDS - 1));
    assign w_new_tot     = sat_add(r_tot[r_pid], w_pts);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= PLAY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PLAY:    if (w_throw && w_last_player && w_last_round) w_state_nxt = FINISH;
            FINISH:  w_state_nxt = DONE;
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = PLAY;
        endcase
    end

    // Argmax with strict '>' so the lowest index keeps a tie
    always_comb begin
        w_best_idx = 3'd0;
        w_best_val = r_tot[0];
        for (int i = 1; i < NUM_PLAYERS; i++) begin
            if (r_tot[i] > w_best_val) begin
                w_best_val = r_tot[i];
                w_best_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PLAYERS; i++) r_tot[i] <= '0;
            r_pid    <= '0;
            r_round  <= '0;
            r_btn_q  <= 1'b0;
            r_disp   <= '0;
            r_final  <= '0;
            r_winner <= '0;
        end else begin
            r_btn_q <= throw_button;
            if (r_state == PLAY && w_throw) begin
                r_tot[r_pid] <= w_new_tot;
                r_disp       <= w_new_tot;
                if (w_last_player) begin
                    r_pid   <= '0;
                    r_round <= r_round + ROUND_W'(1);
                end else begin
                    r_pid <= r_pid + 3'd1;
                end
            end
            if (r_state == FINISH) begin
                r_winner <= 5'd1 << w_best_idx;
                r_final  <= w_best_val;
            end
        end
    end

    assign player_id     = r_pid;
    assign score_display = r_disp;
    assign final_score   = r_final;
    assign winner        = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_digital_dart_game.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_digital_dart_game : scoreboard bench for the dart scorer        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_digital_dart_game;

    localparam int NP = 5;
    localparam int NR = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       throw_button = 1'b0;
    logic [2:0] player_id;
    logic [4:0] score_display;
    logic [4:0] final_score;
    logic [4:0] winner;

    always #5 clk = ~clk;

    digital_dart_game #(
        .NUM_PLAYERS (NP),
        .NUM_ROUNDS  (NR),
        .LFSR_SEED   (8'hA5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .throw_button  (throw_button),
        .player_id     (player_id),
        .score_display (score_display),
        .final_score   (final_score),
        .winner        (winner)
    );

    int total_cnt = 0;
    int bad_cnt   = 0;

    // Reference point generator, stepped alongside the design
    logic [7:0] m_lfsr;
    always @(posedge clk or negedge reset) begin
        if (!reset) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    int m_tot [NP];
    int m_pid, m_round, m_disp;
    bit m_done;

    typedef struct { int pid; int disp; } exp_t;
    exp_t sb[$];

    typedef struct { int hold; int gap; int exp_pid; } vec_t;
    vec_t vecs [6];

    int want [NP];

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act != exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_pts();
        int n;
        n = int'(m_lfsr[3:0]);
        return (n > 10) ? n - 5 : n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) m_tot[i] = 0;
        m_pid = 0; m_round = 0; m_disp = 0; m_done = 0;
        sb.delete();
    endtask

    // Called at a falling edge; drives one throw and checks the edge that detects it
    task automatic do_throw(input int hold, input int gap);
        exp_t e;
        int   nt;
        if (!m_done) begin
            nt = m_tot[m_pid] + m_pts();
            if (nt > 31) nt = 31;
            m_tot[m_pid] = nt;
            m_disp = nt;
            if (m_pid == NP - 1) begin
                m_pid = 0;
                m_round++;
                if (m_round == NR) m_done = 1;
            end else begin
                m_pid++;
            end
        end
        e.pid = m_pid; e.disp = m_disp;
        sb.push_back(e);
        throw_button = 1'b1;
        @(negedge clk);
        e = sb.pop_front();
        check("throw_pid", int'(player_id), e.pid);
        check("throw_disp", int'(score_display), e.disp);
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            check("hold_pid", int'(player_id), e.pid);
            check("hold_disp", int'(score_display), e.disp);
        end
        throw_button = 1'b0;
        for (int i = 0; i < gap; i++) @(negedge clk);
    endtask

    // Wait until the reference LFSR offers the wanted points, then throw
    task automatic throw_for(input int pts, input int gap);
        int waited = 0;
        while (m_pts() != pts && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 400) check("search_timeout", waited, 0);
        do_throw(1, gap);
    endtask

    task automatic check_final(input string tag);
        int b = 0;
        for (int i = 1; i < NP; i++) if (m_tot[i] > m_tot[b]) b = i;
        check({tag, "_winner"}, int'(winner), 1 << b);
        check({tag, "_final"}, int'(final_score), m_tot[b]);
    endtask

    // Final throw, then checks 1 and 2 edges later
    task automatic finish_and_check(input string tag);
        check({tag, "_early_winner"}, int'(winner), 0);
        @(negedge clk);
        @(negedge clk);
        check_final(tag);
        check({tag, "_pid_done"}, int'(player_id), 0);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got t=%0t expected finish earlier", $time);
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1, 3, 1};
        vecs[1] = '{1, 3, 2};
        vecs[2] = '{1, 3, 3};
        vecs[3] = '{1, 3, 4};
        vecs[4] = '{1, 3, 0};
        vecs[5] = '{10, 2, 1};
        want[0] = 1; want[1] = 4; want[2] = 2; want[3] = 4; want[4] = 3;

        // Reset state
        model_reset();
        @(negedge clk);
        check("rst_pid", int'(player_id), 0);
        check("rst_disp", int'(score_display), 0);
        check("rst_final", int'(final_score), 0);
        check("rst_winner", int'(winner), 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_pid", int'(player_id), 0);
        check("idle_disp", int'(score_display), 0);

        // Pulses and one long hold
        for (int v = 0; v < 6; v++) begin
            do_throw(vecs[v].hold, vecs[v].gap);
            check("tbl_pid", int'(player_id), vecs[v].exp_pid);
            if (v < 5) check("tbl_pts_range", int'(score_display <= 5'd10), 1);
        end

        // Complete the 15-throw game
        for (int i = 0; i < 8; i++) do_throw(1, 1 + (i % 3));
        do_throw(1, 0);
        finish_and_check("game1");
        do_throw(1, 1);
        do_throw(3, 2);
        check_final("game1_post");
        check("game1_post_pid", int'(player_id), 0);

        // Tie between players 1 and 3 at 12
        pulse_reset();
        check("tie_rst_winner", int'(winner), 0);
        for (int r = 0; r < NR; r++)
            for (int p = 0; p < NP; p++)
                throw_for(want[p], (r == NR - 1 && p == NP - 1) ? 0 : 1);
        finish_and_check("tie");
        check("tie_winner_const", int'(winner), 5'b00010);
        check("tie_final_const", int'(final_score), 12);

        // Asynchronous reset mid-game, then a fresh game
        pulse_reset();
        for (int i = 0; i < 7; i++) do_throw(1, 1 + (i % 2));
        #2;
        reset = 1'b0;
        #1;
        check("async_pid", int'(player_id), 0);
        check("async_disp", int'(score_display), 0);
        check("async_winner", int'(winner), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 14; i++) do_throw(1, 1 + (i % 3));
        do_throw(1, 0);
        finish_and_check("game3");

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
`default_nettype wire
